// File: rtl/ebike_stim_gen.sv
// eBike bench stimulus: N_CH slew-limited sensor channels, cadence square wave and
// guarded mode-toggle pulses. Define EBIKE_STIM_NOISE_EN to add LFSR dither on ch_out.
module ebike_stim_gen #(
  parameter int N_CH      = 4,
  parameter int DW        = 12,
  parameter int CAD_W     = 16,
  parameter int RAMP_DIV  = 1024,
  parameter int TGGL_HOLD = 1,
  parameter int TGGL_GAP  = 3,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 RST_n,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic [CH_W-1:0]      cmd_ch,
  input  logic [DW-1:0]        cmd_val,
  input  logic [DW-1:0]        cmd_step,
  output logic [N_CH*DW-1:0]   ch_out,
  output logic [N_CH-1:0]      ch_settled,
  input  logic                 cad_ld,
  input  logic [CAD_W-1:0]     cad_rate,
  output logic                 cadence,
  input  logic                 tggl_req,
  output logic                 tgglMd,
  output logic                 tggl_busy
);

  localparam int PW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TMAX = (TGGL_HOLD > TGGL_GAP) ? TGGL_HOLD : TGGL_GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(RAMP_DIV - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(TGGL_HOLD - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'((TGGL_GAP > 0) ? TGGL_GAP - 1 : 0);

  // Move v toward t by at most s, never past t.
  function automatic logic [DW-1:0] ramp_next(input logic [DW-1:0] v,
                                              input logic [DW-1:0] t,
                                              input logic [DW-1:0] s);
    logic [DW-1:0] d;
    d = (t > v) ? t - v : v - t;
    if (s < d) d = s;
    return (t > v) ? v + d : v - d;
  endfunction

  logic          acc;
  logic          acc_q;
  logic [PW-1:0] presc_q;
  logic          tick;

  assign acc     = cmd_vld & cmd_rdy;
  assign cmd_rdy = ~acc_q;
  assign tick    = (presc_q == PRE_LAST);

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      acc_q   <= 1'b0;
      presc_q <= '0;
    end else begin
      acc_q   <= acc;
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

`ifdef EBIKE_STIM_NOISE_EN
  logic [15:0] lfsr_q;

  // Offset by {-1,0,0,+1} chosen by sel, clamped to the DW range.
  function automatic logic [DW-1:0] dither(input logic [DW-1:0] v, input logic [1:0] sel);
    logic [DW-1:0] r;
    r = v;
    case (sel)
      2'b00:   if (v != '0) r = v - 1'b1;
      2'b11:   if (v != '1) r = v + 1'b1;
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n)    lfsr_q <= 16'hACE1;
    else if (tick) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DW-1:0] val_q;
    logic [DW-1:0] tgt_q;
    logic [DW-1:0] stp_q;
    logic          wr;

    assign wr = acc && (cmd_ch == CH_W'(i));

    // Ramp uses the target/step present before this edge; a same-edge write lands next tick.
    always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
        val_q <= '0;
        tgt_q <= '0;
        stp_q <= '0;
      end else begin
        if (stp_q == '0)
          val_q <= tgt_q;
        else if (tick && (val_q != tgt_q))
          val_q <= ramp_next(val_q, tgt_q, stp_q);
        if (wr) begin
          tgt_q <= cmd_val;
          stp_q <= cmd_step;
        end
      end
    end

    assign ch_settled[i] = (val_q == tgt_q);
`ifdef EBIKE_STIM_NOISE_EN
    localparam int LB = (2 * i) % 16;
    localparam int HB = (2 * i + 1) % 16;
    assign ch_out[i*DW +: DW] = dither(val_q, {lfsr_q[HB], lfsr_q[LB]});
`else
    assign ch_out[i*DW +: DW] = val_q;
`endif
  end

  logic [CAD_W-1:0] per_q;
  logic [CAD_W-1:0] ccnt_q;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      per_q  <= '0;
      ccnt_q <= '0;
    end else if (cad_ld) begin
      per_q  <= (cad_rate == CAD_W'(1)) ? CAD_W'(2) : cad_rate;
      ccnt_q <= '0;
    end else if ((per_q == '0) || (ccnt_q == per_q - 1'b1)) begin
      ccnt_q <= '0;
    end else begin
      ccnt_q <= ccnt_q + 1'b1;
    end
  end

  // Low for the first P-P/2 counts of each period, high for the last P/2.
  assign cadence = (per_q != '0) && (ccnt_q >= per_q - (per_q >> 1));

  typedef enum logic [1:0] {T_IDLE, T_HOLD, T_GAP} tggl_state_t;
  tggl_state_t   t_q, t_nx;
  logic [TW-1:0] tcnt_q, tcnt_nx;
  logic          pend_q, pend_nx;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      t_q    <= T_IDLE;
      tcnt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      t_q    <= t_nx;
      tcnt_q <= tcnt_nx;
      pend_q <= pend_nx;
    end
  end

  always_comb begin
    t_nx    = t_q;
    tcnt_nx = tcnt_q + 1'b1;
    pend_nx = pend_q;
    if ((t_q != T_IDLE) && tggl_req) pend_nx = 1'b1;
    case (t_q)
      T_IDLE: begin
        tcnt_nx = '0;
        if (tggl_req) t_nx = T_HOLD;
      end
      T_HOLD: begin
        if (tcnt_q == HOLD_LAST) begin
          tcnt_nx = '0;
          if (TGGL_GAP > 0) begin
            t_nx = T_GAP;
          end else if (pend_nx) begin
            t_nx    = T_HOLD;
            pend_nx = 1'b0;
          end else begin
            t_nx = T_IDLE;
          end
        end
      end
      T_GAP: begin
        if (tcnt_q == GAP_LAST) begin
          tcnt_nx = '0;
          if (pend_nx) begin
            t_nx    = T_HOLD;
            pend_nx = 1'b0;
          end else begin
            t_nx = T_IDLE;
          end
        end
      end
      default: begin
        t_nx    = T_IDLE;
        tcnt_nx = '0;
      end
    endcase
  end

  assign tgglMd    = (t_q == T_HOLD);
  assign tggl_busy = (t_q != T_IDLE) | pend_q;

endmodule

// File: tb/tb_ebike_stim_gen.sv
// Scoreboard bench for ebike_stim_gen: expectations are queued by cycle when
// stimulus is driven and compared at the negedge of that cycle.
module tb_ebike_stim_gen;

  localparam int N_CH     = 3;
  localparam int DW       = 12;
  localparam int CAD_W    = 16;
  localparam int RAMP_DIV = 4;
  localparam int C_SET    = 8;
  localparam int C_RDY    = 16;
  localparam int C_CAD    = 17;
  localparam int C_TGL    = 18;
  localparam int C_BSY    = 19;

  logic               clk = 1'b0;
  logic               RST_n;
  logic               cmd_vld;
  logic               cmd_rdy;
  logic [1:0]         cmd_ch;
  logic [DW-1:0]      cmd_val;
  logic [DW-1:0]      cmd_step;
  logic [N_CH*DW-1:0] ch_out;
  logic [N_CH-1:0]    ch_settled;
  logic               cad_ld;
  logic [CAD_W-1:0]   cad_rate;
  logic               cadence;
  logic               tggl_req;
  logic               tgglMd;
  logic               tggl_busy;

  always #5 clk = ~clk;

  ebike_stim_gen #(
    .N_CH(N_CH), .DW(DW), .CAD_W(CAD_W), .RAMP_DIV(RAMP_DIV),
    .TGGL_HOLD(1), .TGGL_GAP(3)
  ) dut (
    .clk(clk), .RST_n(RST_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_ch(cmd_ch),
    .cmd_val(cmd_val), .cmd_step(cmd_step),
    .ch_out(ch_out), .ch_settled(ch_settled),
    .cad_ld(cad_ld), .cad_rate(cad_rate), .cadence(cadence),
    .tggl_req(tggl_req), .tgglMd(tgglMd), .tggl_busy(tggl_busy)
  );

  typedef struct {
    int          cyc;
    int          code;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   rel_cyc = 0;
  int   n_vec   = 0;
  int   n_miss  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  function automatic string tag_of(input int code);
    if (code < N_CH) return $sformatf("ch_out[%0d]", code);
    if (code >= C_SET && code < C_SET + N_CH) return $sformatf("ch_settled[%0d]", code - C_SET);
    case (code)
      C_RDY:   return "cmd_rdy";
      C_CAD:   return "cadence";
      C_TGL:   return "tgglMd";
      C_BSY:   return "tggl_busy";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] sample(input int code);
    if (code < N_CH) return 32'(ch_out[code*DW +: DW]);
    if (code >= C_SET && code < C_SET + N_CH) return 32'(ch_settled[code-C_SET]);
    case (code)
      C_RDY:   return 32'(cmd_rdy);
      C_CAD:   return 32'(cadence);
      C_TGL:   return 32'(tgglMd);
      C_BSY:   return 32'(tggl_busy);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic sb_push(input int c, input int code, input logic [31:0] v);
    exp_t e;
    int   idx;
    e.cyc  = c;
    e.code = code;
    e.val  = v;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].cyc > c) idx--;
    sb.insert(idx, e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk(tag_of(e.code), sample(e.code), e.val);
    end
  end

  task automatic step_clk();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 300) begin
      step_clk();
      t++;
    end
    if (sb.size() > 0) begin
      chk("sb_drain", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  function automatic bit is_tick(input int c);
    return (c > rel_cyc) && (((c - rel_cyc) % RAMP_DIV) == 0);
  endfunction

  // Expected channel value from the accept cycle a onward, n cycles.
  task automatic exp_ramp(input int ch, input int a, input logic [DW-1:0] v0,
                          input logic [DW-1:0] tgt, input logic [DW-1:0] stp, input int n);
    logic [DW-1:0] v;
    logic [DW-1:0] d;
    v = v0;
    for (int k = 0; k < n; k++) begin
      if (k >= 1) begin
        if (stp == '0) begin
          v = tgt;
        end else if (is_tick(a + k) && v != tgt) begin
          d = (tgt > v) ? tgt - v : v - tgt;
          if (stp < d) d = stp;
          v = (tgt > v) ? v + d : v - d;
        end
      end
      sb_push(a + k, ch, 32'(v));
      sb_push(a + k, C_SET + ch, (v == tgt) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic send_cmd(input logic [1:0] ch, input logic [DW-1:0] v, input logic [DW-1:0] s);
    sb_push(cyc + 1, C_RDY, 32'd0);
    sb_push(cyc + 2, C_RDY, 32'd1);
    cmd_vld  = 1'b1;
    cmd_ch   = ch;
    cmd_val  = v;
    cmd_step = s;
    step_clk();
    cmd_vld  = 1'b0;
  endtask

  task automatic cad_load(input logic [CAD_W-1:0] rate, input int n);
    int p;
    int c0;
    p  = (rate == 1) ? 2 : int'(rate);
    c0 = cyc + 1;
    for (int k = 0; k < n; k++)
      sb_push(c0 + k, C_CAD, (p != 0 && (k % p) >= (p - p / 2)) ? 32'd1 : 32'd0);
    cad_ld   = 1'b1;
    cad_rate = rate;
    step_clk();
    cad_ld   = 1'b0;
  endtask

  task automatic push_reset_state(input int c);
    for (int i = 0; i < N_CH; i++) begin
      sb_push(c, i, 32'd0);
      sb_push(c, C_SET + i, 32'd1);
    end
    sb_push(c, C_RDY, 32'd1);
    sb_push(c, C_CAD, 32'd0);
    sb_push(c, C_TGL, 32'd0);
    sb_push(c, C_BSY, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    int c;
    RST_n    = 1'b0;
    cmd_vld  = 1'b1;
    cmd_ch   = 2'd0;
    cmd_val  = 12'hABC;
    cmd_step = '0;
    cad_ld   = 1'b0;
    cad_rate = '0;
    tggl_req = 1'b0;
    step_clk();
    step_clk();
    push_reset_state(cyc + 1);
    step_clk();
    cmd_vld = 1'b0;
    RST_n   = 1'b1;
    rel_cyc = cyc;
    repeat (3) step_clk();

    // Ramp up, short final step, then ramp down without wrapping.
    a = cyc + 1;
    exp_ramp(0, a, 12'h000, 12'h100, 12'h040, 20);
    send_cmd(2'd0, 12'h100, 12'h040);
    drain();
    a = cyc + 1;
    exp_ramp(0, a, 12'h100, 12'h0F0, 12'h040, 8);
    send_cmd(2'd0, 12'h0F0, 12'h040);
    drain();
    a = cyc + 1;
    exp_ramp(0, a, 12'h0F0, 12'h010, 12'h050, 16);
    send_cmd(2'd0, 12'h010, 12'h050);
    drain();

    // Immediate jump, then an out-of-range channel that must be ignored.
    a = cyc + 1;
    exp_ramp(1, a, 12'h000, 12'hFFF, 12'h000, 4);
    send_cmd(2'd1, 12'hFFF, 12'h000);
    drain();
    a = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      sb_push(a + k, 0, 32'h010);
      sb_push(a + k, 1, 32'hFFF);
      sb_push(a + k, 2, 32'h000);
      sb_push(a + k, C_SET + 2, 32'd1);
    end
    send_cmd(2'd3, 12'h555, 12'h000);
    drain();

    // Cadence periods 10, 1 (clamped to 2) and 0.
    cad_load(16'd10, 25);
    drain();
    cad_load(16'd1, 8);
    drain();
    cad_load(16'd0, 10);
    drain();

    // Three back-to-back toggle requests.
    c = cyc;
    for (int k = 1; k <= 11; k++) begin
      sb_push(c + k, C_TGL, (k == 1 || k == 5) ? 32'd1 : 32'd0);
      sb_push(c + k, C_BSY, (k <= 8) ? 32'd1 : 32'd0);
    end
    tggl_req = 1'b1;
    repeat (3) step_clk();
    tggl_req = 1'b0;
    drain();

    // Asynchronous reset while channel 2 ramps and the toggle pulse is high.
    a = cyc + 1;
    exp_ramp(2, a, 12'h000, 12'h800, 12'h010, 8);
    send_cmd(2'd2, 12'h800, 12'h010);
    repeat (7) step_clk();
    push_reset_state(cyc + 1);
    tggl_req = 1'b1;
    @(posedge clk);
    #1;
    RST_n    = 1'b0;
    tggl_req = 1'b0;
    step_clk();
    step_clk();
    RST_n   = 1'b1;
    rel_cyc = cyc;
    push_reset_state(cyc + 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
